// File: rtl/op_lut_hdr_rewrite.sv
// -----------------------------------------------------------------------------
// op_lut_hdr_rewrite
//
// Purpose:
//   This block sits at the tail of the output-port-lookup pipeline and rewrites
//   Ethernet/IPv4 header fields as packets stream through. Each packet is
//   rewritten according to a descriptor that the block reads from the head of
//   a descriptor FIFO:
//     - MAC DA and MAC SA are always overwritten.
//     - Optionally, the IP TTL is decremented and the IP header checksum is
//       updated incrementally.
//   The block adds one cycle of latency and holds at most one word.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   in_data/in_ctrl    input word and control (nonzero = module header or EOP)
//   in_wr / in_rdy     input valid / block can accept a word
//   out_data/out_ctrl  registered output word and control
//   out_wr             registered output valid
//   out_rdy            downstream can take at least 2 more words
//   rw_vld / rw_rd     descriptor present / pop descriptor (combinational)
//   rw_mac_da/sa       new MAC addresses
//   rw_dec_ttl         decrement TTL and fix the checksum
// -----------------------------------------------------------------------------
module op_lut_hdr_rewrite #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  rw_vld,
    output logic                  rw_rd,
    input  logic [47:0]           rw_mac_da,
    input  logic [47:0]           rw_mac_sa,
    input  logic                  rw_dec_ttl
);

    typedef enum logic [2:0] {
        MODULE_HDRS,
        WORD_1,
        WORD_2,
        WORD_3,
        PAYLOAD
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic                  cks_fix_reg;
    logic                  cks_fix_next;
    logic [DATA_WIDTH-1:0] data_next;

    logic                  ctrl_word;
    logic [7:0]            ttl;
    logic [16:0]           cks_sum;
    logic [15:0]           cks_new;

    assign ctrl_word = |in_ctrl;
    assign ttl       = in_data[15:8];

    // TTL is the high byte of its 16-bit checksum word, so decrementing it
    // means adding 0x0100 to the one's-complement checksum, with the carry
    // folded back in.
    assign cks_sum = {1'b0, in_data[63:48]} + 17'h00100;
    assign cks_new = cks_sum[15:0] + {15'b0, cks_sum[16]};

    // A packet may not start until its descriptor is at the FIFO head.
    assign in_rdy = out_rdy & (rw_vld | (state_reg != MODULE_HDRS));

    // Any control word after the module headers is the EOP word. The
    // descriptor is popped on that word. During reset the packet is
    // abandoned, so the descriptor is left in place.
    assign rw_rd = in_wr & ctrl_word & (state_reg != MODULE_HDRS) & ~reset;

    always_comb begin
        data_next    = in_data;
        state_next   = state_reg;
        cks_fix_next = cks_fix_reg;

        case (state_reg)
            MODULE_HDRS: begin
                if (!ctrl_word) begin
                    data_next  = {rw_mac_da, rw_mac_sa[47:32]};
                    state_next = WORD_1;
                end
            end
            WORD_1: begin
                data_next[63:32] = rw_mac_sa[31:0];
                state_next       = WORD_2;
            end
            WORD_2: begin
                // Never wrap a TTL of zero; leave that packet alone.
                if (rw_dec_ttl && (ttl != 8'd0)) begin
                    data_next[15:8] = ttl - 8'd1;
                    cks_fix_next    = 1'b1;
                end else begin
                    cks_fix_next    = 1'b0;
                end
                state_next = WORD_3;
            end
            WORD_3: begin
                if (cks_fix_reg) begin
                    data_next[63:48] = cks_new;
                end
                state_next = PAYLOAD;
            end
            PAYLOAD: begin
                state_next = PAYLOAD;
            end
            default: begin
                state_next = MODULE_HDRS;
            end
        endcase

        // EOP ends the packet in any state after the module headers, even
        // if some rewrites were never reached.
        if ((state_reg != MODULE_HDRS) && ctrl_word) begin
            state_next = MODULE_HDRS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= MODULE_HDRS;
            cks_fix_reg <= 1'b0;
            out_data    <= '0;
            out_ctrl    <= '0;
            out_wr      <= 1'b0;
        end else begin
            out_ctrl <= in_ctrl;
            out_wr   <= in_wr;
            if (in_wr) begin
                out_data    <= data_next;
                state_reg   <= state_next;
                cks_fix_reg <= cks_fix_next;
            end
        end
    end

endmodule

// File: tb/tb_op_lut_hdr_rewrite.sv
// -----------------------------------------------------------------------------
// tb_op_lut_hdr_rewrite
//
// Directed testbench for op_lut_hdr_rewrite. Inputs are driven just after the
// falling edge. Combinational outputs are sampled 1 ns later, and registered
// outputs are sampled 1 ns after the following rising edge. Expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_op_lut_hdr_rewrite;

    localparam logic [47:0] DA = 48'h0011_2233_4455;
    localparam logic [47:0] SA = 48'h6677_8899_AABB;

    localparam logic [63:0] HDR  = 64'h0004_0000_0040_0000;
    localparam logic [63:0] W0   = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [63:0] W1   = 64'hEEEE_FFFF_0800_4500;
    localparam logic [63:0] EOPW = 64'h0102_0304_0506_0708;

    localparam logic [63:0] W0_EXP = 64'h0011_2233_4455_6677;
    localparam logic [63:0] W1_EXP = 64'h8899_AABB_0800_4500;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic        rw_vld;
    logic        rw_rd;
    logic [47:0] rw_mac_da;
    logic [47:0] rw_mac_sa;
    logic        rw_dec_ttl;

    int tests = 0;
    int fails = 0;

    op_lut_hdr_rewrite dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .in_wr      (in_wr),
        .in_rdy     (in_rdy),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .out_wr     (out_wr),
        .out_rdy    (out_rdy),
        .rw_vld     (rw_vld),
        .rw_rd      (rw_rd),
        .rw_mac_da  (rw_mac_da),
        .rw_mac_sa  (rw_mac_sa),
        .rw_dec_ttl (rw_dec_ttl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Sends one word and checks rw_rd/in_rdy in the same cycle, then checks
    // out_* one cycle later. Must be called just after a falling edge.
    task automatic send_word(input string tag, input logic [63:0] d, input logic [7:0] c,
                             input logic [63:0] exp_d, input logic exp_rd);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        #1;
        chk({tag, ".in_rdy"}, {63'b0, in_rdy}, 64'd1);
        chk({tag, ".rw_rd"}, {63'b0, rw_rd}, {63'b0, exp_rd});
        @(posedge clk);
        #1;
        in_wr = 1'b0;
        chk({tag, ".out_wr"}, {63'b0, out_wr}, 64'd1);
        chk({tag, ".out_data"}, out_data, exp_d);
        chk({tag, ".out_ctrl"}, {56'b0, out_ctrl}, {56'b0, c});
        $display("[TB] %s data=%h ctrl=%h -> out=%h", tag, d, c, out_data);
        @(negedge clk);
    endtask

    task automatic idle_cycle(input string tag);
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        @(posedge clk);
        #1;
        chk({tag, ".out_wr"}, {63'b0, out_wr}, 64'd0);
        @(negedge clk);
    endtask

    // Sends a full packet: module header, four header words and EOP.
    task automatic send_pkt(input string tag, input logic [7:0] ttl, input logic [15:0] cks,
                            input logic dec, input logic [7:0] exp_ttl,
                            input logic [15:0] exp_cks);
        logic [63:0] w2;
        logic [63:0] w3;
        w2 = {48'h0028_0000_4000, ttl, 8'h06};
        w3 = {cks, 48'hC0A8_0001_C0A8};
        rw_dec_ttl = dec;
        send_word({tag, ".hdr"}, HDR, 8'hFF, HDR, 1'b0);
        send_word({tag, ".w0"}, W0, 8'h00, W0_EXP, 1'b0);
        send_word({tag, ".w1"}, W1, 8'h00, W1_EXP, 1'b0);
        send_word({tag, ".w2"}, w2, 8'h00, {48'h0028_0000_4000, exp_ttl, 8'h06}, 1'b0);
        send_word({tag, ".w3"}, w3, 8'h00, {exp_cks, 48'hC0A8_0001_C0A8}, 1'b0);
        send_word({tag, ".eop"}, EOPW, 8'h80, EOPW, 1'b1);
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_ctrl    = '0;
        in_wr      = 1'b0;
        out_rdy    = 1'b1;
        rw_vld     = 1'b0;
        rw_mac_da  = DA;
        rw_mac_sa  = SA;
        rw_dec_ttl = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.out_wr", {63'b0, out_wr}, 64'd0);
        chk("rst.out_data", out_data, 64'd0);
        chk("rst.out_ctrl", {56'b0, out_ctrl}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.in_rdy_novld", {63'b0, in_rdy}, 64'd0);
        chk("rst.rw_rd", {63'b0, rw_rd}, 64'd0);
        @(negedge clk);

        // Test 4: the descriptor arrives late, and in_rdy follows rw_vld.
        idle_cycle("t4.wait");
        #1;
        chk("t4.in_rdy_low", {63'b0, in_rdy}, 64'd0);
        rw_vld = 1'b1;
        #1;
        chk("t4.in_rdy_high", {63'b0, in_rdy}, 64'd1);
        @(negedge clk);

        // Test 1: the basic rewrite with a TTL decrement.
        send_pkt("t1", 8'h40, 16'hB1E6, 1'b1, 8'h3F, 16'hB2E6);
        idle_cycle("t1.idle");

        // Test 2: the checksum wraps with an end-around carry.
        send_pkt("t2", 8'h40, 16'hFF80, 1'b1, 8'h3F, 16'h0081);

        // Test 3: TTL 0 is left unchanged; with dec=0 nothing is changed.
        send_pkt("t3a", 8'h00, 16'hB1E6, 1'b1, 8'h00, 16'hB1E6);
        send_pkt("t3b", 8'h40, 16'hB1E6, 1'b0, 8'h40, 16'hB1E6);

        // Test 5: back-pressure for 3 cycles mid-packet.
        rw_dec_ttl = 1'b1;
        send_word("t5.hdr", HDR, 8'hFF, HDR, 1'b0);
        send_word("t5.w0", W0, 8'h00, W0_EXP, 1'b0);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5.in_rdy_low", {63'b0, in_rdy}, 64'd0);
            idle_cycle("t5.stall");
        end
        out_rdy = 1'b1;
        send_word("t5.w1", W1, 8'h00, W1_EXP, 1'b0);
        send_word("t5.w2", 64'h0028_0000_4000_4006, 8'h00, 64'h0028_0000_4000_3F06, 1'b0);
        send_word("t5.w3", 64'hB1E6_C0A8_0001_C0A8, 8'h00, 64'hB2E6_C0A8_0001_C0A8, 1'b0);
        send_word("t5.eop", EOPW, 8'h80, EOPW, 1'b1);

        // Test 6: reset during WORD_2 abandons the packet without a pop.
        send_word("t6.hdr", HDR, 8'hFF, HDR, 1'b0);
        send_word("t6.w0", W0, 8'h00, W0_EXP, 1'b0);
        send_word("t6.w1", W1, 8'h00, W1_EXP, 1'b0);
        in_data = 64'h0028_0000_4000_4006;
        in_ctrl = 8'h80;
        in_wr   = 1'b1;
        reset   = 1'b1;
        #1;
        chk("t6.rw_rd_in_reset", {63'b0, rw_rd}, 64'd0);
        @(posedge clk);
        #1;
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        chk("t6.out_wr", {63'b0, out_wr}, 64'd0);
        chk("t6.out_data", out_data, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        send_pkt("t6.next", 8'h40, 16'hB1E6, 1'b1, 8'h3F, 16'hB2E6);

        // A short packet: an EOP on word 1 is still rewritten, then the FSM
        // returns to the header state.
        send_word("sp.hdr", HDR, 8'hFF, HDR, 1'b0);
        send_word("sp.w0", W0, 8'h00, W0_EXP, 1'b0);
        send_word("sp.eop", W1, 8'h01, W1_EXP, 1'b1);
        send_word("sp.next_w0", W0, 8'h00, W0_EXP, 1'b0);
        send_word("sp.next_eop", W1, 8'h01, W1_EXP, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/op_lut_hdr_rewrite.md
Name: op_lut_hdr_rewrite

Overview:
- Transmit-side counterpart of the output-port-lookup header parser; sits at the tail of the output_port_lookup pipeline, just before the output queues.
- Streams 64-bit NetFPGA packets (module headers, then Ethernet/IPv4) and rewrites header fields on the fly, as directed by a per-packet rewrite descriptor:
  - overwrites MAC DA and MAC SA;
  - optionally decrements the IP TTL and incrementally updates the IP header checksum.
- Adds one cycle of latency and never stores more than one word.

Parameters:
DATA_WIDTH, 64, datapath width; the field map below requires exactly 64.
CTRL_WIDTH, DATA_WIDTH/8, control width.

Ports:
clk  in  1  clock.
reset  in  1  reset; synchronous, active-high.
in_data  in  DATA_WIDTH  input word.
in_ctrl  in  CTRL_WIDTH  input control; nonzero marks a module header word or the EOP word.
in_wr  in  1  input word valid; legal only while in_rdy=1.
in_rdy  out  1  block can accept a word this cycle.
out_data  out  DATA_WIDTH  output word (registered).
out_ctrl  out  CTRL_WIDTH  output control (registered).
out_wr  out  1  output word valid (registered).
out_rdy  in  1  downstream can accept at least 2 more words.
rw_vld  in  1  rewrite descriptor available at head of descriptor FIFO.
rw_rd  out  1  pops the descriptor; combinational.
rw_mac_da  in  48  new MAC destination address.
rw_mac_sa  in  48  new MAC source address.
rw_dec_ttl  in  1  1 = decrement TTL and update checksum.

Behaviour:
- Reset values: out_data=0, out_ctrl=0, out_wr=0, state=MODULE_HDRS. Reset mid-packet abandons the packet and does not pop the descriptor.
- in_rdy = out_rdy & (rw_vld | state!=MODULE_HDRS). No word of a packet is accepted until its descriptor is present.
- Latency: every accepted word appears on out_* exactly 1 cycle later with out_wr=1. When no word is accepted, out_wr=0 in the next cycle. out_ctrl is always in_ctrl delayed by 1 cycle.
- Descriptor fields are read directly from the FIFO head; they stay stable until rw_rd.
- States and transitions (the FSM advances only on in_wr):
  - MODULE_HDRS:
    - in_ctrl!=0: pass the word unchanged.
    - in_ctrl==0 (word 0): out_data[63:16]=rw_mac_da, out_data[15:0]=rw_mac_sa[47:32]; go to WORD_1.
  - WORD_1: out_data[63:32]=rw_mac_sa[31:0]; [31:0] unchanged; go to WORD_2.
  - WORD_2: TTL is in_data[15:8].
    - If rw_dec_ttl=1 and TTL!=0: output TTL-1, set internal flag cks_fix=1.
    - Otherwise: TTL unchanged, cks_fix=0.
    - Other bits unchanged; go to WORD_3.
  - WORD_3: checksum is in_data[63:48].
    - If cks_fix=1: 17-bit sum s = cks + 16'h0100; output s[15:0] + s[16] (end-around carry, 16-bit result).
    - Other bits unchanged; go to PAYLOAD.
  - PAYLOAD: pass words unchanged.
- EOP handling:
  - In any state other than MODULE_HDRS, an accepted word with in_ctrl!=0 is the EOP word.
  - On EOP: rw_rd=1 in that same cycle, and next state = MODULE_HDRS.
  - This applies to short packets too: an EOP in WORD_1..WORD_3 aborts the remaining rewrites, but the fields of the EOP word itself are still rewritten per its state.
- rw_rd is asserted at no other time. Exactly one pop per packet.
- Non-IP frames are still rewritten per the descriptor. The upstream lookup sets rw_dec_ttl=0 for them.
- Simultaneous events: rw_vld falling while in_wr is low in MODULE_HDRS only lowers in_rdy. out_rdy low forces in_rdy low; upstream must not write.

Test Plan:
1. rw_vld=1, da=0x001122334455, sa=0x66778899AABB, dec=1; packet = 1 module hdr (ctrl=0xFF) + word0 + word1 + word2 (TTL=0x40, proto=0x06) + word3 (cksum=0xB1E6) + EOP (ctrl=0x80) -> header unchanged; word0=0x001122334455_6677; word1[63:32]=0x8899AABB; TTL=0x3F; cksum=0xB2E6; rw_rd high only on the EOP cycle; each word out 1 cycle after in.
2. Same packet, cksum=0xFF80, dec=1 -> cksum out = 0x0081 (carry wrap).
3. TTL=0x00, dec=1 -> TTL stays 0x00, cksum unchanged. dec=0 with TTL=0x40 -> both unchanged.
4. rw_vld=0 at packet start -> in_rdy=0. Raise rw_vld -> in_rdy=1 the same cycle; packet proceeds.
5. Toggle out_rdy low for 3 cycles mid-packet -> in_rdy low for the same cycles; output data intact, no duplicate or lost words.
6. Assert reset during WORD_2 -> out_wr=0 the next cycle, no rw_rd. The next packet is rewritten correctly from word0.
